// File: rtl/fp16_pair_feeder.sv
// Operand feeder for the FP16 adder: pairs a stream of elements into (a, b) operands,
// pads the odd tail of a vector with PAD_VALUE and queues pairs in a small FIFO.
module fp16_pair_feeder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] PAD_VALUE = 16'h0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_elem_valid,
  output logic                     o_elem_ready,
  input  logic [15:0]              i_elem_data,
  input  logic                     i_elem_last,
  output logic                     o_pair_valid,
  input  logic                     i_pair_ready,
  output logic [15:0]              o_pair_a,
  output logic [15:0]              o_pair_b,
  output logic                     o_pair_last,
  output logic                     o_pair_padded,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {StIdle, StHaveA} state_e;

  state_e      r_state;
  logic [15:0] r_held;
  logic [33:0] r_mem [DEPTH];
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  logic        r_elem_ready;

  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic        w_empty;
  logic        w_full_nxt;
  logic [33:0] w_wdata;
  logic [33:0] w_head;
  logic [PW:0] w_wptr_nxt;
  logic [PW:0] w_rptr_nxt;

  assign w_accept = i_elem_valid && r_elem_ready;
  // A write happens when a pair is completed or a vector ends on an unpaired element.
  assign w_wr     = w_accept && ((r_state == StHaveA) || i_elem_last);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_rd     = !w_empty && i_pair_ready;

  always_comb begin
    w_wdata = {i_elem_data, PAD_VALUE, 1'b1, 1'b1};
    if (r_state == StHaveA) begin
      w_wdata = {r_held, i_elem_data, i_elem_last, 1'b0};
    end
  end

  assign w_wptr_nxt = r_wptr + {{PW{1'b0}}, w_wr};
  assign w_rptr_nxt = r_rptr + {{PW{1'b0}}, w_rd};
  assign w_full_nxt = (w_wptr_nxt == {~w_rptr_nxt[PW], w_rptr_nxt[PW-1:0]});

  // Ready is registered from next-state fullness, so it has no path from the inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_held       <= 16'h0000;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_elem_ready <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_elem_ready <= !w_full_nxt;
      if (w_wr) begin
        r_mem[r_wptr[PW-1:0]] <= w_wdata;
      end
      if (w_accept) begin
        unique case (r_state)
          StIdle: begin
            if (!i_elem_last) begin
              r_held  <= i_elem_data;
              r_state <= StHaveA;
            end
          end
          StHaveA: begin
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign w_head        = r_mem[r_rptr[PW-1:0]];
  assign o_elem_ready  = r_elem_ready;
  assign o_pair_valid  = !w_empty;
  assign o_pair_a      = w_head[33:18];
  assign o_pair_b      = w_head[17:2];
  assign o_pair_last   = w_head[1];
  assign o_pair_padded = w_head[0];
  assign o_fifo_count  = r_wptr - r_rptr;

endmodule

// File: tb/tb_fp16_pair_feeder.sv
// Bench for fp16_pair_feeder: element table plus directed fill/drain/reset sequences,
// with a scoreboard of expected pairs checked whenever a pair is consumed.
module tb_fp16_pair_feeder;

  logic        clk;
  logic        rst;
  logic        elem_valid;
  logic        elem_ready;
  logic [15:0] elem_data;
  logic        elem_last;
  logic        pair_valid;
  logic        pair_ready;
  logic [15:0] pair_a;
  logic [15:0] pair_b;
  logic        pair_last;
  logic        pair_padded;
  logic [2:0]  fifo_count;

  fp16_pair_feeder #(
    .DEPTH    (4),
    .PAD_VALUE(16'h0000)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_elem_valid (elem_valid),
    .o_elem_ready (elem_ready),
    .i_elem_data  (elem_data),
    .i_elem_last  (elem_last),
    .o_pair_valid (pair_valid),
    .i_pair_ready (pair_ready),
    .o_pair_a     (pair_a),
    .o_pair_b     (pair_b),
    .o_pair_last  (pair_last),
    .o_pair_padded(pair_padded),
    .o_fifo_count (fifo_count)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic        pad;
  } pair_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        push;
    pair_t       exp;
  } vec_t;

  pair_t       sb[$];
  pair_t       mon_exp;
  int          checks = 0;
  int          errors = 0;
  bit          m_have = 0;
  logic [15:0] m_held = 16'h0000;
  vec_t        tbl[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Consumption happens on the next rising edge; sample after the driver settles.
  always begin
    @(negedge clk);
    #2;
    if (!rst && pair_valid && pair_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pair got %h/%h/%b/%b expected none",
                 pair_a, pair_b, pair_last, pair_padded);
      end else begin
        mon_exp = sb.pop_front();
        if ({pair_a, pair_b, pair_last, pair_padded} !== mon_exp) begin
          errors++;
          $display("FAIL pair_out got %h/%h/%b/%b expected %h/%h/%b/%b",
                   pair_a, pair_b, pair_last, pair_padded,
                   mon_exp.a, mon_exp.b, mon_exp.last, mon_exp.pad);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic drive(input logic [15:0] d, input logic l);
    int t = 0;
    elem_valid = 1'b1;
    elem_data  = d;
    elem_last  = l;
    while (!elem_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("elem_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    elem_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    pair_t p;
    if (m_have) begin
      p = '{a: m_held, b: d, last: l, pad: 1'b0};
      sb.push_back(p);
      m_have = 0;
    end else if (l) begin
      p = '{a: d, b: 16'h0000, last: 1'b1, pad: 1'b1};
      sb.push_back(p);
    end else begin
      m_held = d;
      m_have = 1;
    end
    drive(d, l);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h3C00, 1'b0, 1'b0, '{16'h0000, 16'h0000, 1'b0, 1'b0}};
    tbl[1] = '{16'h4000, 1'b1, 1'b1, '{16'h3C00, 16'h4000, 1'b1, 1'b0}};
    tbl[2] = '{16'h4200, 1'b1, 1'b1, '{16'h4200, 16'h0000, 1'b1, 1'b1}};
    tbl[3] = '{16'h0001, 1'b0, 1'b0, '{16'h0000, 16'h0000, 1'b0, 1'b0}};
    tbl[4] = '{16'h0002, 1'b0, 1'b1, '{16'h0001, 16'h0002, 1'b0, 1'b0}};
    tbl[5] = '{16'h0003, 1'b1, 1'b1, '{16'h0003, 16'h0000, 1'b1, 1'b1}};
    tbl[6] = '{16'h0004, 1'b0, 1'b0, '{16'h0000, 16'h0000, 1'b0, 1'b0}};
    tbl[7] = '{16'h0005, 1'b1, 1'b1, '{16'h0004, 16'h0005, 1'b1, 1'b0}};

    rst        = 1'b1;
    elem_valid = 1'b0;
    elem_data  = 16'h0000;
    elem_last  = 1'b0;
    pair_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_elem_ready", 32'(elem_ready), 32'd0);
    chk("rst_pair_valid", 32'(pair_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_head", {pair_a, pair_b}, 32'd0);
    chk("rst_last_pad", {30'd0, pair_last, pair_padded}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_elem_ready", 32'(elem_ready), 32'd1);

    // Table: pairing, padding and back-to-back vectors with the adder always ready.
    pair_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].push) sb.push_back(tbl[i].exp);
      drive(tbl[i].data, tbl[i].last);
      if (tbl[i].push) begin
        chk($sformatf("lat_valid_%0d", i), 32'(pair_valid), 32'd1);
        chk($sformatf("lat_head_%0d", i), {pair_a, pair_b}, {tbl[i].exp.a, tbl[i].exp.b});
        @(negedge clk);
        chk($sformatf("lat_count_%0d", i), 32'(fifo_count), 32'd0);
      end else begin
        chk($sformatf("nowrite_count_%0d", i), 32'(fifo_count), 32'd0);
      end
    end
    wait_drain();

    // Fill to full with the adder stalled, then drain in order.
    pair_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(16'(i), (i == 8));
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_elem_ready", 32'(elem_ready), 32'd0);
    pair_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_read", 32'(elem_ready), 32'd1);
    chk("count_after_read", 32'(fifo_count), 32'd3);
    wait_drain();

    // Simultaneous read and pair-completing write keeps the count.
    pair_ready = 1'b0;
    for (int i = 11; i <= 18; i++) send(16'(i), (i == 18));
    chk("full2_count", 32'(fifo_count), 32'd4);
    pair_ready = 1'b1;
    @(negedge clk);
    pair_ready = 1'b0;
    chk("one_read_count", 32'(fifo_count), 32'd3);
    send(16'd19, 1'b0);
    chk("held_count", 32'(fifo_count), 32'd3);
    pair_ready = 1'b1;
    send(16'd20, 1'b1);
    pair_ready = 1'b0;
    chk("rw_same_cycle_count", 32'(fifo_count), 32'd3);
    @(negedge clk);
    chk("rw_count_stable", 32'(fifo_count), 32'd3);
    pair_ready = 1'b1;
    wait_drain();

    // Reset mid-operation discards queued pairs and the held element.
    pair_ready = 1'b0;
    send(16'h0007, 1'b0);
    send(16'h0008, 1'b1);
    send(16'h3C00, 1'b0);
    chk("pre_rst_valid", 32'(pair_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(pair_valid), 32'd0);
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    sb.delete();
    m_have = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pair_ready = 1'b1;
    send(16'h4000, 1'b0);
    send(16'h4400, 1'b1);
    chk("post_rst_pair_a", 32'(pair_a), 32'h4000);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
